alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Micro-sequencer that feeds the 16-bit instruction port of the ALU/register-file datapath. It loads a short program byte-serially over the 8-bit pin interface into a local instruction buffer. On `start` it issues the instructions one at a time with the two-phase timing the datapath needs: registered operand read, then ALU/write-back. It captures each 8-bit result and zero flag, and reports completion. It sits between the top-level pins and the datapath and replaces direct pin-driven instruction entry.

## Interface
- `DEPTH`, 8, instruction buffer entries; must be a power of 2, ≥2.
- `AW`, 3, log2(DEPTH).

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_valid`  in  1  byte present on `load_data`.
- `load_data`  in  8  program byte; low byte of an instruction first, then high byte.
- `load_ready`  out  1  byte accepted when `load_valid & load_ready`.
- `clear`  in  1  empty the buffer; honoured in IDLE only.
- `start`  in  1  run the program; honoured in IDLE only.
- `dp_inst`  out  16  instruction to datapath: [2:0] opcode, [6:3] func, [9:7] rs2, [12:10] rs1, [15:13] rd; 0 outside READ/EXEC.
- `dp_wr_en`  out  1  register write qualifier to datapath.
- `dp_result`  in  8  datapath ALU result.
- `dp_zero`  in  1  datapath zero flag.
- `result`  out  8  last captured result.
- `zero`  out  1  last captured zero flag.
- `result_valid`  out  1  one-cycle pulse; new `result`/`zero`.
- `busy`  out  1  high in READ and EXEC.
- `done`  out  1  one-cycle pulse at end of run.
- `pc`  out  AW  index of the instruction being issued.
- `count`  out  AW+1  instructions held in the buffer.
- `ovf_err`  out  1  sticky; set when a byte is offered while the buffer is full in IDLE.

## Operation
- States: IDLE, READ, EXEC, DONE.
- **Reset:** state IDLE, buffer count 0, byte phase 0, `pc` 0, all outputs 0 except `load_ready`=1.
- **IDLE:**
  - `load_ready` = (`count` < DEPTH).
  - Phase-0 byte goes to a low-byte holding register, and phase toggles to 1.
  - Phase-1 byte writes {byte, low} to `buf[count]`, increments `count`, and phase returns to 0.
  - `load_valid` while `count`==DEPTH sets `ovf_err`; the byte is dropped.
- **`clear`:** sets `count` 0, phase 0 and `ovf_err` 0. `clear` has priority over `start` and over a load in the same cycle.
- **`start` in IDLE:**
  - Discards any half-loaded byte (phase → 0) and sets `pc` 0.
  - If `count`==0, go to DONE; otherwise go to READ.
  - A load beat coincident with `start` is not accepted (`load_ready` is 0 that cycle when `start`=1).
- **READ:**
  - `dp_inst` = `buf[pc]`, `dp_wr_en` 0. The datapath registers its operands at the end of this cycle.
  - Next state EXEC.
- **EXEC:**
  - `dp_inst` = `buf[pc]`, `dp_wr_en` = (opcode==3'b011).
  - At the closing edge: `result` ← `dp_result`, `zero` ← `dp_zero`, `result_valid` pulses high the next cycle.
  - If opcode==3'b111 (HALT) or `pc`==`count`−1, go to DONE. Otherwise `pc`++ and go to READ.
  - HALT still executes as an ALU op: its result is captured, and it does not write back.
- **DONE:** `done`=1 for one cycle, then IDLE. Buffer contents and `count` are retained, so a later `start` re-runs the same program.
- **While busy:** `load_ready`=0; `start`, `clear` and `load_valid` are ignored.
- **Reset mid-run:** immediately returns to IDLE, empties the buffer and clears `result`; `dp_wr_en` drops asynchronously.

## Timing
- `start` sampled at edge E0 → READ during cycle E0..E1, EXEC during E1..E2, `result_valid` high E2..E3.
- Each instruction takes exactly 2 cycles; back-to-back instructions have no bubble.
- N-instruction run: `busy` high 2N cycles. `done` is high in the cycle after the last EXEC, coincident with the final `result_valid`.
- `start` with an empty buffer: `done` the cycle after E0, `busy` never asserts, no `result_valid`.
- `dp_wr_en` is high only during EXEC, so the datapath writes at most once per instruction.
- All outputs are registered or decoded from state/buffer only; there is no combinational path from `dp_*` inputs to outputs.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-EXEC → `busy`=0, `dp_wr_en`=0, `count`=0, `result`=0 immediately; `load_ready`=1 after release.
- **Single-op run:** load bytes 0x30, 0x0D (ADD rs1=3, rs2=2); model returns 0x05; `start` → `dp_inst`=0x0D30 for 2 cycles, `dp_wr_en`=0, `result`=0x05, `zero`=0, one `done`.
- **Multi-op run with write:** load 3 instructions; 2nd = 0x0D33 (opcode 011) → `dp_wr_en` high exactly 1 cycle (2nd EXEC), `pc` steps 0,1,2, `busy` 6 cycles, 3 `result_valid` pulses.
- **HALT:** program [0x0D30, 0x0007, 0x0D30] → run stops after `pc`=1; `done` after 4 busy cycles; third instruction never on `dp_inst`.
- **Full buffer:** load 8 instructions, then offer byte 0xAA → `load_ready`=0, `ovf_err`=1, `count`=8. Then `clear` → `count`=0, `ovf_err`=0.
- **Edge cases:**
  - `start` with `count`=0 → `done` next cycle, no `busy`.
  - `start` after a single low byte → partial byte discarded, `count` unchanged.
  - `start`/`clear`/load during `busy` → ignored.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_ctrl
//  Brief    : Micro-sequencer that loads a short 16-bit program byte-serially
//             and issues it to the ALU/register-file datapath with two-phase
//             (operand read, then execute/write-back) timing.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid_i,
  input  logic [7:0]    load_data_i,
  output logic          load_ready_o,
  input  logic          clear_i,
  input  logic          start_i,
  output logic [15:0]   dp_inst_o,
  output logic          dp_wr_en_o,
  input  logic [7:0]    dp_result_i,
  input  logic          dp_zero_i,
  output logic [7:0]    result_o,
  output logic          zero_o,
  output logic          result_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] pc_o,
  output logic [AW:0]   count_o,
  output logic          ovf_err_o
);

  localparam logic [2:0]  c_OP_WR   = 3'b011;
  localparam logic [2:0]  c_OP_HALT = 3'b111;
  localparam logic [AW:0] c_FULL    = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [15:0]   buf_q [DEPTH];
  logic [AW:0]   count_q;
  logic          phase_q;
  logic [7:0]    low_q;
  logic [AW-1:0] pc_q;
  logic          ovf_q;
  logic [7:0]    result_q;
  logic          zero_q;
  logic          rv_q;
  logic          done_q;
  logic          busy_q;

  logic          w_idle;
  logic          w_full;
  logic          w_accept;
  logic          w_issue;
  logic [15:0]   w_cur;
  logic          w_last;
  logic          w_halt;

  assign w_idle   = (state_q == S_IDLE);
  assign w_full   = (count_q == c_FULL);
  // A byte is taken only in IDLE, when there is room, and when neither
  // start nor clear claims the cycle (clear wins over a load).
  assign w_accept = w_idle && !start_i && !clear_i && load_valid_i && !w_full;
  assign w_issue  = (state_q == S_READ) || (state_q == S_EXEC);
  assign w_cur    = buf_q[pc_q];
  assign w_last   = (({1'b0, pc_q} + 1'b1) == count_q);
  assign w_halt   = (w_cur[2:0] == c_OP_HALT);

  // Outputs decoded purely from state and buffer contents; no dp_* feedthrough.
  assign load_ready_o   = w_idle && !start_i && !w_full;
  assign dp_inst_o      = w_issue ? w_cur : 16'h0000;
  assign dp_wr_en_o     = (state_q == S_EXEC) && (w_cur[2:0] == c_OP_WR);
  assign result_o       = result_q;
  assign zero_o         = zero_q;
  assign result_valid_o = rv_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pc_o           = pc_q;
  assign count_o        = count_q;
  assign ovf_err_o      = ovf_q;

  // Instruction storage: the high byte completes an entry together with the held low byte.
  always_ff @(posedge clk) begin
    if (w_accept && phase_q) begin
      buf_q[count_q[AW-1:0]] <= {load_data_i, low_q};
    end
  end

  // Sequencer FSM with loader bookkeeping and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      phase_q  <= 1'b0;
      low_q    <= 8'h00;
      pc_q     <= '0;
      ovf_q    <= 1'b0;
      result_q <= 8'h00;
      zero_q   <= 1'b0;
      rv_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_i) begin
            count_q <= '0;
            phase_q <= 1'b0;
            ovf_q   <= 1'b0;
          end else if (start_i) begin
            // A half-loaded instruction is abandoned when a run begins.
            phase_q <= 1'b0;
            pc_q    <= '0;
            if (count_q == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
            end
          end else if (load_valid_i && w_full) begin
            ovf_q <= 1'b1;
          end else if (w_accept) begin
            if (!phase_q) begin
              low_q   <= load_data_i;
              phase_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
              phase_q <= 1'b0;
            end
          end
        end
        S_READ: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= dp_result_i;
          zero_q   <= dp_zero_i;
          rv_q     <= 1'b1;
          if (w_halt || w_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            pc_q    <= pc_q + 1'b1;
            state_q <= S_READ;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_ctrl
//  Brief    : Directed self-checking bench for alu_seq_ctrl with a tiny
//             datapath model (register i holds value i; result = rs1 + rs2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        clear;
  logic        start;
  logic [15:0] dp_inst;
  logic        dp_wr_en;
  logic [7:0]  dp_result;
  logic        dp_zero;
  logic [7:0]  result;
  logic        zero;
  logic        result_valid;
  logic        busy;
  logic        done;
  logic [2:0]  pc;
  logic [3:0]  count;
  logic        ovf_err;

  int checks   = 0;
  int failures = 0;

  alu_seq_ctrl #(.DEPTH(8), .AW(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_valid_i  (load_valid),
    .load_data_i   (load_data),
    .load_ready_o  (load_ready),
    .clear_i       (clear),
    .start_i       (start),
    .dp_inst_o     (dp_inst),
    .dp_wr_en_o    (dp_wr_en),
    .dp_result_i   (dp_result),
    .dp_zero_i     (dp_zero),
    .result_o      (result),
    .zero_o        (zero),
    .result_valid_o(result_valid),
    .busy_o        (busy),
    .done_o        (done),
    .pc_o          (pc),
    .count_o       (count),
    .ovf_err_o     (ovf_err)
  );

  always #5 clk = ~clk;

  // Datapath model: register i holds value i, so result = rs1 + rs2.
  always_comb begin
    dp_result = {5'b0, dp_inst[12:10]} + {5'b0, dp_inst[9:7]};
    dp_zero   = (dp_result == 8'h00);
  end

  // Stimulus helpers (no checking inside); all enter and leave at a negedge.
  task automatic load_byte(input logic [7:0] b);
    load_valid = 1'b1; load_data = b;
    @(negedge clk);
    load_valid = 1'b0; load_data = 8'h00;
  endtask

  task automatic load_inst(input logic [15:0] w);
    load_byte(w[7:0]);
    load_byte(w[15:8]);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dp_inst !== 16'h0000) begin failures++; $display("FAIL reset_dp_inst got=%h exp=0000", dp_inst); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    checks++; if ({done, result_valid, ovf_err, dp_wr_en} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {done, result_valid, ovf_err, dp_wr_en}); end
    checks++; if ({result, zero, pc} !== 12'h000) begin failures++; $display("FAIL reset_result_pc got=%h exp=000", {result, zero, pc}); end
  endtask

  task automatic test_single();
    pulse_clear();
    load_inst(16'h0D30);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    pulse_start();
    // READ
    checks++; if (dp_inst !== 16'h0D30) begin failures++; $display("FAIL single_read_inst got=%h exp=0d30", dp_inst); end
    checks++; if ({busy, dp_wr_en, load_ready} !== 3'b100) begin failures++; $display("FAIL single_read_ctl got=%b exp=100", {busy, dp_wr_en, load_ready}); end
    @(negedge clk);
    // EXEC
    checks++; if (dp_inst !== 16'h0D30) begin failures++; $display("FAIL single_exec_inst got=%h exp=0d30", dp_inst); end
    checks++; if ({busy, dp_wr_en} !== 2'b10) begin failures++; $display("FAIL single_exec_ctl got=%b exp=10", {busy, dp_wr_en}); end
    @(negedge clk);
    // DONE
    checks++; if ({busy, done, result_valid} !== 3'b011) begin failures++; $display("FAIL single_done_ctl got=%b exp=011", {busy, done, result_valid}); end
    checks++; if ({result, zero} !== {8'h05, 1'b0}) begin failures++; $display("FAIL single_result got=%h/%b exp=05/0", result, zero); end
    checks++; if (dp_inst !== 16'h0000) begin failures++; $display("FAIL single_done_inst got=%h exp=0000", dp_inst); end
    @(negedge clk);
    checks++; if ({done, result_valid, load_ready} !== 3'b001) begin failures++; $display("FAIL single_idle_ctl got=%b exp=001", {done, result_valid, load_ready}); end
  endtask

  task automatic test_multi();
    logic [15:0] prog [3];
    logic [7:0]  exp_res [3];
    int n_busy, n_wr, n_rv, n_done;
    prog[0] = 16'h0D30; prog[1] = 16'h0D33; prog[2] = 16'h1C00;
    exp_res[0] = 8'h05; exp_res[1] = 8'h05; exp_res[2] = 8'h07;
    n_busy = 0; n_wr = 0; n_rv = 0; n_done = 0;
    pulse_clear();
    for (int i = 0; i < 3; i++) load_inst(prog[i]);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        checks++; if (dp_inst !== prog[k/2]) begin failures++; $display("FAIL multi_inst k=%0d got=%h exp=%h", k, dp_inst, prog[k/2]); end
        checks++; if (pc !== 3'(k/2)) begin failures++; $display("FAIL multi_pc k=%0d got=%0d exp=%0d", k, pc, k/2); end
      end
      if (busy) n_busy++;
      if (dp_wr_en) begin
        n_wr++;
        checks++; if (k != 3) begin failures++; $display("FAIL multi_wr_cycle got=%0d exp=3", k); end
      end
      if (result_valid) begin
        if (n_rv < 3) begin
          checks++; if (result !== exp_res[n_rv]) begin failures++; $display("FAIL multi_result n=%0d got=%h exp=%h", n_rv, result, exp_res[n_rv]); end
        end
        n_rv++;
      end
      if (done) begin
        n_done++;
        checks++; if (k != 6) begin failures++; $display("FAIL multi_done_cycle got=%0d exp=6", k); end
      end
      @(negedge clk);
    end
    checks++; if (n_busy != 6) begin failures++; $display("FAIL multi_busy_cycles got=%0d exp=6", n_busy); end
    checks++; if (n_wr != 1) begin failures++; $display("FAIL multi_wr_count got=%0d exp=1", n_wr); end
    checks++; if (n_rv != 3) begin failures++; $display("FAIL multi_rv_count got=%0d exp=3", n_rv); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL multi_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_halt();
    int n_busy, done_at, pc2_seen;
    n_busy = 0; done_at = -1; pc2_seen = 0;
    pulse_clear();
    load_inst(16'h0D30); load_inst(16'h0007); load_inst(16'h0D30);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      if (busy) n_busy++;
      if (busy && pc == 3'd2) pc2_seen++;
      if (done && done_at < 0) begin
        done_at = k;
        checks++; if ({result, zero} !== {8'h00, 1'b1}) begin failures++; $display("FAIL halt_result got=%h/%b exp=00/1", result, zero); end
      end
      if (k == 3) begin
        checks++; if ({dp_inst, dp_wr_en} !== {16'h0007, 1'b0}) begin failures++; $display("FAIL halt_exec got=%h/%b exp=0007/0", dp_inst, dp_wr_en); end
      end
      @(negedge clk);
    end
    checks++; if (n_busy != 4) begin failures++; $display("FAIL halt_busy_cycles got=%0d exp=4", n_busy); end
    checks++; if (done_at != 4) begin failures++; $display("FAIL halt_done_cycle got=%0d exp=4", done_at); end
    checks++; if (pc2_seen != 0) begin failures++; $display("FAIL halt_third_issued got=%0d exp=0", pc2_seen); end
  endtask

  task automatic test_full();
    pulse_clear();
    for (int i = 0; i < 8; i++) load_inst(16'(i));
    checks++; if ({count, load_ready} !== {4'd8, 1'b0}) begin failures++; $display("FAIL full_count_ready got=%0d/%b exp=8/0", count, load_ready); end
    load_byte(8'hAA);
    checks++; if ({count, ovf_err} !== {4'd8, 1'b1}) begin failures++; $display("FAIL full_ovf got=%0d/%b exp=8/1", count, ovf_err); end
    pulse_clear();
    checks++; if ({count, ovf_err, load_ready} !== {4'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL full_clear got=%0d/%b/%b exp=0/0/1", count, ovf_err, load_ready); end
  endtask

  task automatic test_empty_start();
    int n_busy, n_rv;
    n_busy = 0; n_rv = 0;
    pulse_clear();
    pulse_start();
    checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL empty_done got=%b exp=10", {done, busy}); end
    for (int k = 0; k < 4; k++) begin
      if (busy) n_busy++;
      if (result_valid) n_rv++;
      @(negedge clk);
    end
    checks++; if ({n_busy, n_rv} != {32'd0, 32'd0}) begin failures++; $display("FAIL empty_activity got=%0d/%0d exp=0/0", n_busy, n_rv); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_done_width got=%b exp=0", done); end
  endtask

  task automatic test_partial();
    pulse_clear();
    load_inst(16'h0D30);
    load_byte(8'h55);
    pulse_start();
    repeat (3) @(negedge clk);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL partial_count got=%0d exp=1", count); end
    load_inst(16'h0D33);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL partial_count2 got=%0d exp=2", count); end
    pulse_start();
    repeat (2) @(negedge clk);
    checks++; if (dp_inst !== 16'h0D33) begin failures++; $display("FAIL partial_inst1 got=%h exp=0d33", dp_inst); end
    repeat (3) @(negedge clk);
  endtask

  // Buffer holds [0x0D30, 0x0D33] from the previous scenario.
  task automatic test_busy_ignore();
    int n_busy;
    n_busy = 0;
    pulse_start();
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL busy_load_ready got=%b exp=0", load_ready); end
    start = 1'b1; clear = 1'b1; load_valid = 1'b1; load_data = 8'h77;
    @(negedge clk);
    start = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    for (int k = 1; k < 8; k++) begin
      if (busy) n_busy++;
      @(negedge clk);
    end
    checks++; if (n_busy != 3) begin failures++; $display("FAIL busy_ignore_cycles got=%0d exp=3", n_busy); end
    checks++; if ({count, ovf_err} !== {4'd2, 1'b0}) begin failures++; $display("FAIL busy_ignore_state got=%0d/%b exp=2/0", count, ovf_err); end
  endtask

  // Buffer holds [0x0D30, 0x0D33]; reset lands in the second EXEC.
  task automatic test_reset_mid_run();
    pulse_start();
    repeat (3) @(negedge clk);
    checks++; if ({busy, dp_wr_en, result} !== {1'b1, 1'b1, 8'h05}) begin failures++; $display("FAIL midrun_pre got=%b/%b/%h exp=1/1/05", busy, dp_wr_en, result); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, dp_wr_en, count, result} !== {1'b0, 1'b0, 4'd0, 8'h00}) begin failures++; $display("FAIL midrun_reset got=%b/%b/%0d/%h exp=0/0/0/00", busy, dp_wr_en, count, result); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({load_ready, done, result_valid, pc} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin failures++; $display("FAIL midrun_release got=%b/%b/%b/%0d exp=1/0/0/0", load_ready, done, result_valid, pc); end
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; clear = 1'b0; start = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_halt();
    test_full();
    test_empty_start();
    test_partial();
    test_busy_ignore();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
